rc4_crack_sequencer: RTL

// Top-level sequencer for the RC4 key-search datapath. For each candidate key it runs

---
 rtl/rc4_pkg.sv | 47 ++++
 rtl/rc4_s_port_mux.sv | 51 +++++
 rtl/rc4_crack_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and helpers for the RC4 key-search sequencer
//
// Contents:
//   stage_t       stage index / s-RAM port owner (NONE = nobody drives the port)
//   seq_state_t   sequencer FSM states
//   is_plain_char accepted plaintext alphabet: lowercase letters and space
//   state_owner   which stage owns the s-RAM port in a given FSM state
package rc4_pkg;

    typedef enum logic [1:0] {
        STG_INIT = 2'd0,
        STG_KSA  = 2'd1,
        STG_DEC  = 2'd2,
        STG_NONE = 2'd3
    } stage_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_JUDGE,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_FAIL,
        ST_ERROR
    } seq_state_t;

    function automatic logic is_plain_char(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // The port is handed over in the GO state so the stage owns it from its
    // very first cycle, and stays with it until the stage reports done.
    function automatic stage_t state_owner(input seq_state_t s);
        case (s)
            ST_INIT_GO, ST_INIT_WAIT: return STG_INIT;
            ST_KSA_GO,  ST_KSA_WAIT:  return STG_KSA;
            ST_DEC_GO,  ST_DEC_WAIT:  return STG_DEC;
            default:                  return STG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_s_port_mux.sv
// rtl/rc4_s_port_mux.sv - owner-selected 3:1 s-RAM port mux
//
// Ports:
//   owner    in  2      stage owning the port (STG_NONE = idle)
//   st_addr  in  3x8    per-stage address
//   st_data  in  3x8    per-stage write data
//   st_wren  in  3      per-stage write enable
//   s_addr   out 8      selected address (0 when idle)
//   s_data   out 8      selected write data (0 when idle)
//   s_wren   out 1      selected write enable, forced 0 when idle
module rc4_s_port_mux
    import rc4_pkg::*;
(
    input  logic [1:0]      owner,
    input  logic [2:0][7:0] st_addr,
    input  logic [2:0][7:0] st_data,
    input  logic [2:0]      st_wren,
    output logic [7:0]      s_addr,
    output logic [7:0]      s_data,
    output logic            s_wren
);

    always_comb begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
        case (owner)
            STG_INIT: begin
                s_addr = st_addr[0];
                s_data = st_data[0];
                s_wren = st_wren[0];
            end
            STG_KSA: begin
                s_addr = st_addr[1];
                s_data = st_data[1];
                s_wren = st_wren[1];
            end
            STG_DEC: begin
                s_addr = st_addr[2];
                s_data = st_data[2];
                s_wren = st_wren[2];
            end
            default: begin
                s_addr = 8'h00;
                s_data = 8'h00;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_crack_sequencer.sv
// rtl/rc4_crack_sequencer.sv - RC4 key-search sequencer: stage FSM, key stepping, byte screen
//
// Ports:
//   clock, i_reset     clock, synchronous active-high reset
//   start              pulse; begins a search from IDLE/FOUND/FAIL/ERROR
//   stage_go[2:0]      one-hot start pulse to init/ksa/decrypt stage
//   stage_done[2:0]    finish pulses from the stages (only the owner's bit counts)
//   st_addr/st_data/st_wren   per-stage s-RAM port requests
//   s_addr/s_data/s_wren      s-RAM port, driven by the owning stage only
//   dec_wren/dec_data  plaintext bytes written by the decrypt stage
//   secret_key[23:0]   current candidate key (zero-extended)
//   busy/found/fail/error     status levels; stage_err = stage that timed out
module rc4_crack_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_W     = 22,
    parameter int unsigned KEY_START = 0,
    parameter int unsigned KEY_STEP  = 1,
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned WDOG_CYC  = 4096
)(
    input  logic            clock,
    input  logic            i_reset,
    input  logic            start,
    output logic [2:0]      stage_go,
    input  logic [2:0]      stage_done,
    input  logic [2:0][7:0] st_addr,
    input  logic [2:0][7:0] st_data,
    input  logic [2:0]      st_wren,
    output logic [7:0]      s_addr,
    output logic [7:0]      s_data,
    output logic            s_wren,
    input  logic            dec_wren,
    input  logic [7:0]      dec_data,
    output logic [23:0]     secret_key,
    output logic            busy,
    output logic            found,
    output logic            fail,
    output logic            error,
    output logic [1:0]      stage_err
);

    localparam int unsigned       WDOG_W    = $clog2(WDOG_CYC) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    localparam logic [KEY_W-1:0]  KEY_INIT  = KEY_W'(KEY_START);
    localparam logic [KEY_W:0]    STEP_EXT  = (KEY_W + 1)'(KEY_STEP);
    localparam logic [5:0]        MSG_CNT   = 6'(MSG_LEN);

    seq_state_t        state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [1:0]        owner_q, owner_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              bad_q, bad_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        go_q, go_d;
    logic              busy_q, busy_d;
    logic              found_q, found_d;
    logic              fail_q, fail_d;
    logic              error_q, error_d;
    logic [1:0]        err_stage_q, err_stage_d;

    // One extra bit so running off the top of the key space is visible.
    logic [KEY_W:0]    nxt_key;
    logic              own_done;
    seq_state_t        wait_next;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        wdog_d      = wdog_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;
        err_stage_d = err_stage_q;
        nxt_key     = {1'b0, key_q} + STEP_EXT;
        own_done    = 1'b0;
        wait_next   = state_q;

        // Only the current owner's done bit can advance a WAIT state.
        case (state_q)
            ST_INIT_WAIT: begin own_done = stage_done[0]; wait_next = ST_KSA_GO; end
            ST_KSA_WAIT:  begin own_done = stage_done[1]; wait_next = ST_DEC_GO; end
            ST_DEC_WAIT:  begin own_done = stage_done[2]; wait_next = ST_JUDGE;  end
            default:      begin own_done = 1'b0;          wait_next = state_q;   end
        endcase

        case (state_q)
            ST_IDLE, ST_FOUND, ST_FAIL, ST_ERROR: begin
                if (start) begin
                    state_d     = ST_INIT_GO;
                    key_d       = KEY_INIT;
                    err_stage_d = 2'd0;
                end
            end
            ST_INIT_GO: begin
                wdog_d  = '0;
                state_d = ST_INIT_WAIT;
            end
            ST_KSA_GO: begin
                wdog_d  = '0;
                state_d = ST_KSA_WAIT;
            end
            ST_DEC_GO: begin
                wdog_d  = '0;
                bad_d   = 1'b0;
                cnt_d   = 6'd0;
                state_d = ST_DEC_WAIT;
            end
            ST_INIT_WAIT, ST_KSA_WAIT, ST_DEC_WAIT: begin
                // A done in the last watchdog cycle still counts as success.
                if (own_done) begin
                    state_d = wait_next;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d     = ST_ERROR;
                    err_stage_d = owner_q;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_JUDGE: begin
                // A short or long message is treated the same as garbage text.
                if (!bad_q && (cnt_q == MSG_CNT)) begin
                    state_d = ST_FOUND;
                end else begin
                    state_d = ST_NEXT_KEY;
                end
            end
            ST_NEXT_KEY: begin
                if (nxt_key[KEY_W]) begin
                    state_d = ST_FAIL;
                end else begin
                    key_d   = nxt_key[KEY_W-1:0];
                    state_d = ST_INIT_GO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_DEC_WAIT) && dec_wren) begin
            cnt_d = cnt_q + 6'd1;
            if (!is_plain_char(dec_data)) begin
                bad_d = 1'b1;
            end
        end

        // Outputs are registered from the next state so they line up with it.
        go_d      = {state_d == ST_DEC_GO, state_d == ST_KSA_GO, state_d == ST_INIT_GO};
        owner_d   = state_owner(state_d);
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_FOUND) ||
                      (state_d == ST_FAIL) || (state_d == ST_ERROR));
        found_d   = (state_d == ST_FOUND);
        fail_d    = (state_d == ST_FAIL);
        error_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            key_q       <= KEY_INIT;
            owner_q     <= STG_NONE;
            wdog_q      <= '0;
            bad_q       <= 1'b0;
            cnt_q       <= 6'd0;
            go_q        <= 3'b000;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            fail_q      <= 1'b0;
            error_q     <= 1'b0;
            err_stage_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            owner_q     <= owner_d;
            wdog_q      <= wdog_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            found_q     <= found_d;
            fail_q      <= fail_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
        end
    end

    rc4_s_port_mux u_port_mux (
        .owner   (owner_q),
        .st_addr (st_addr),
        .st_data (st_data),
        .st_wren (st_wren),
        .s_addr  (s_addr),
        .s_data  (s_data),
        .s_wren  (s_wren)
    );

    assign stage_go   = go_q;
    assign secret_key = 24'(key_q);
    assign busy       = busy_q;
    assign found      = found_q;
    assign fail       = fail_q;
    assign error      = error_q;
    assign stage_err  = err_stage_q;

endmodule
